// File: rtl/mem_bus_if.sv
// Wishbone master bridge for the MEM stage: one bus access per request, with
// ack/timeout/flush handling and a hold-off state while the pipeline is stalled.
//
// state        | meaning
// S_IDLE       | no bus cycle; accepts a new request from the MEM stage
// S_BUSY       | cyc/stb asserted, waiting for ack, flush or timeout
// S_WAIT_STALL | access done, load data parked in rd_buf until stall_i drops
module mem_bus_if #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_BUSY       = 2'd1,
        S_WAIT_STALL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_rd_buf;
    logic        r_bus_err;

    logic w_busy;
    logic w_launch;
    logic w_ack;
    logic w_abort;
    logic w_flush_busy;

    assign w_busy       = (r_state == S_BUSY);
    assign w_launch     = (r_state == S_IDLE) && cpu_ce_i && !flush_i;
    assign w_flush_busy = w_busy && flush_i;
    // flush outranks ack, and ack outranks timeout, within the same cycle
    assign w_ack        = w_busy && !flush_i && wb_ack_i;
    assign w_abort      = w_busy && !flush_i && !wb_ack_i && (r_cnt == TIMEOUT);

    assign bus_err_o = r_bus_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_next = S_IDLE;
                end else if (wb_ack_i) begin
                    w_next = stall_i ? S_WAIT_STALL : S_IDLE;
                end else if (r_cnt == TIMEOUT) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_STALL: begin
                if (flush_i || !stall_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    stallreq_o = cpu_ce_i && !flush_i;
                    cpu_data_o = r_rd_buf;
                end
                S_BUSY: begin
                    stallreq_o = !wb_ack_i && !flush_i;
                    if (w_ack && !wb_we_o) begin
                        cpu_data_o = wb_dat_i;
                    end
                end
                S_WAIT_STALL: begin
                    cpu_data_o = r_rd_buf;
                end
                default: begin
                    stallreq_o = 1'b0;
                    cpu_data_o = 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_adr_o  <= 32'h0;
            wb_dat_o  <= 32'h0;
            wb_sel_o  <= 4'h0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            r_rd_buf  <= 32'h0;
            r_cnt     <= 8'h0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if (w_launch) begin
                wb_adr_o <= cpu_addr_i;
                wb_dat_o <= cpu_data_i;
                wb_sel_o <= cpu_sel_i;
                wb_we_o  <= cpu_we_i;
                wb_stb_o <= 1'b1;
                wb_cyc_o <= 1'b1;
                r_cnt    <= 8'h0;
            end else if (w_flush_busy || w_ack || w_abort) begin
                wb_adr_o <= 32'h0;
                wb_dat_o <= 32'h0;
                wb_sel_o <= 4'h0;
                wb_we_o  <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_cyc_o <= 1'b0;
                if (w_flush_busy || w_abort) begin
                    r_rd_buf <= 32'h0;
                end else if (!wb_we_o) begin
                    r_rd_buf <= wb_dat_i;
                end
            end else if (w_busy && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: load, store, stall hold-off, flush, timeout
// and reset-in-BUSY, with hand-computed expectations.
module tb_mem_bus_if;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_if #(.TIMEOUT(8'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_sel_i  (cpu_sel_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .bus_err_o  (bus_err_o),
        .wb_ack_i   (wb_ack_i),
        .wb_dat_i   (wb_dat_i),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // advance one edge; inputs change 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // present a request in IDLE, take the launch edge, then withdraw ce
    task automatic launch(input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        cpu_sel_i  = sel;
        step();
        cpu_ce_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0; cpu_sel_i = 4'h0; stall_i = 1'b0; flush_i = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
        step();
        sample();
        check("rst_stallreq", {31'h0, stallreq_o}, 32'h0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        check("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err_o}, 32'h0);
        step();
        rst = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;

        // load, ack on third BUSY cycle
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10; cpu_sel_i = 4'hF;
        sample();
        check("ld_idle_stallreq", {31'h0, stallreq_o}, 32'h1);
        step();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("ld_busy_stallreq", {31'h0, stallreq_o}, 32'h1);
            check("ld_busy_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
            check("ld_busy_adr", wb_adr_o, 32'h10);
            step();
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        sample();
        check("ld_ack_stallreq", {31'h0, stallreq_o}, 32'h0);
        check("ld_ack_data", cpu_data_o, 32'hDEAD_BEEF);
        step();
        wb_ack_i = 1'b0; wb_dat_i = 32'h5555_5555;
        sample();
        check("ld_done_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("ld_done_adr", wb_adr_o, 32'h0);
        check("ld_done_rdbuf", cpu_data_o, 32'hDEAD_BEEF);

        // ack while IDLE must be ignored
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        sample();
        check("idle_ack_data", cpu_data_o, 32'hDEAD_BEEF);
        check("idle_ack_cyc", {31'h0, wb_cyc_o}, 32'h0);

        // store; cpu_* changes after launch must not leak onto the bus
        step();
        launch(1'b1, 32'h20, 32'h1234_5678, 4'b0011);
        cpu_we_i = 1'b0; cpu_data_i = 32'hFFFF_FFFF; cpu_sel_i = 4'hF; cpu_addr_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("st_dat", wb_dat_o, 32'h1234_5678);
            check("st_sel_we", {27'h0, wb_sel_o, wb_we_o}, {27'h0, 4'b0011, 1'b1});
            check("st_adr", wb_adr_o, 32'h20);
            step();
        end
        wb_ack_i = 1'b1;
        sample();
        check("st_ack_data", cpu_data_o, 32'h0);
        step();
        wb_ack_i = 1'b0;
        sample();
        check("st_done_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("st_done_we", {31'h0, wb_we_o}, 32'h0);
        check("st_rdbuf_kept", cpu_data_o, 32'hDEAD_BEEF);

        // ack under stall -> WAIT_STALL, no relaunch while held
        step();
        launch(1'b0, 32'h30, 32'h0, 4'hF);
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; stall_i = 1'b1;
        step();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0; cpu_ce_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("ws_data", cpu_data_o, 32'hCAFE_F00D);
            check("ws_stallreq", {31'h0, stallreq_o}, 32'h0);
            check("ws_cyc", {31'h0, wb_cyc_o}, 32'h0);
            step();
        end
        stall_i = 1'b0;
        step();
        cpu_ce_i = 1'b0;
        sample();
        check("ws_exit_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("ws_exit_data", cpu_data_o, 32'hCAFE_F00D);

        // timeout: TIMEOUT=4 -> abort after the fifth BUSY cycle
        step();
        launch(1'b0, 32'h50, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            sample();
            check("to_busy_cyc", {31'h0, wb_cyc_o}, 32'h1);
            check("to_busy_err", {31'h0, bus_err_o}, 32'h0);
            step();
        end
        sample();
        check("to_err_pulse", {31'h0, bus_err_o}, 32'h1);
        check("to_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("to_data", cpu_data_o, 32'h0);
        check("to_stallreq", {31'h0, stallreq_o}, 32'h0);
        step();
        sample();
        check("to_err_once", {31'h0, bus_err_o}, 32'h0);

        // refill rd_buf, then flush+ack together must clear it
        step();
        launch(1'b0, 32'h60, 32'h0, 4'hF);
        wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_A5A5;
        step();
        wb_ack_i = 1'b0;
        sample();
        check("refill_data", cpu_data_o, 32'hA5A5_A5A5);
        step();
        launch(1'b0, 32'h40, 32'h0, 4'hF);
        wb_ack_i = 1'b1; flush_i = 1'b1; wb_dat_i = 32'h1111_1111;
        sample();
        check("fl_ack_data", cpu_data_o, 32'h0);
        check("fl_ack_stallreq", {31'h0, stallreq_o}, 32'h0);
        step();
        wb_ack_i = 1'b0; flush_i = 1'b0;
        sample();
        check("fl_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("fl_rdbuf", cpu_data_o, 32'h0);

        // reset while BUSY
        step();
        launch(1'b1, 32'h70, 32'h7777_7777, 4'hF);
        step();
        rst = 1'b1;
        sample();
        check("rb_stallreq", {31'h0, stallreq_o}, 32'h0);
        check("rb_data", cpu_data_o, 32'h0);
        step();
        sample();
        check("rb_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("rb_adr", wb_adr_o, 32'h0);
        check("rb_dat", wb_dat_o, 32'h0);
        check("rb_sel_we", {27'h0, wb_sel_o, wb_we_o}, 32'h0);
        check("rb_err", {31'h0, bus_err_o}, 32'h0);
        rst = 1'b0;
        step();
        sample();
        check("rb_after_err", {31'h0, bus_err_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
